// File: rtl/mem_sched_pkg.sv
// rtl/mem_sched_pkg.sv - shared types and region decode for the memory request scheduler
package mem_sched_pkg;

    // Widest address and largest rule table the region decode handles; callers zero-extend.
    localparam int unsigned MaxAddrWidth = 64;
    localparam int unsigned MaxNiRules   = 8;

    typedef enum logic [1:0] {
        ARB,
        DRAIN,
        HOLD,
        SERIAL
    } sched_state_e;

    typedef logic [MaxNiRules-1:0][MaxAddrWidth-1:0] ni_rule_tab_t;

    // An address is non-idempotent when it falls in [base, base+length) of any enabled rule.
    // The upper bound is formed one bit wider so a region ending at the top of memory does not wrap.
    function automatic logic is_non_idempotent(
        input logic [MaxAddrWidth-1:0] addr,
        input ni_rule_tab_t            base,
        input ni_rule_tab_t            length,
        input int unsigned             nr_rules
    );
        logic                  hit;
        logic [MaxAddrWidth:0] limit;
        hit = 1'b0;
        for (int unsigned r = 0; r < MaxNiRules; r++) begin
            limit = {1'b0, base[r]} + {1'b0, length[r]};
            if ((r < nr_rules) && (length[r] != '0) && (addr >= base[r]) && ({1'b0, addr} < limit)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/mem_sched_rr_pick.sv
// rtl/mem_sched_rr_pick.sv - combinational round-robin picker
module mem_sched_rr_pick #(
    parameter int unsigned NrPorts  = 3,
    parameter int unsigned IdxWidth = 2
) (
    input  logic [NrPorts-1:0]  valid,
    input  logic [IdxWidth-1:0] ptr,
    output logic [IdxWidth-1:0] winner,
    output logic                any_valid
);

    int unsigned         idx;
    logic [IdxWidth-1:0] idx_sel;

    // Scan from the pointer upwards, wrapping, and take the first valid port.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        idx       = 0;
        idx_sel   = '0;
        for (int unsigned off = 0; off < NrPorts; off++) begin
            idx = 32'(ptr) + off;
            if (idx >= NrPorts) begin
                idx = idx - NrPorts;
            end
            idx_sel = IdxWidth'(idx);
            if (!any_valid && valid[idx_sel]) begin
                any_valid = 1'b1;
                winner    = idx_sel;
            end
        end
    end

endmodule

// File: rtl/mem_req_scheduler.sv
// rtl/mem_req_scheduler.sv - round-robin memory request scheduler with outstanding cap and NI serialization
module mem_req_scheduler
    import mem_sched_pkg::*;
#(
    parameter int unsigned NrPorts        = 3,
    parameter int unsigned AddrWidth      = 64,
    parameter int unsigned IdWidth        = 4,
    parameter int unsigned MaxOutstanding = 7,
    parameter int unsigned NrNiRules      = 2,
    parameter logic [NrNiRules-1:0][AddrWidth-1:0] NiAddrBase = '0,
    parameter logic [NrNiRules-1:0][AddrWidth-1:0] NiLength   = '0
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NrPorts-1:0]                     req_valid_i,
    output logic [NrPorts-1:0]                     req_ready_o,
    input  logic [NrPorts-1:0][AddrWidth-1:0]      req_addr_i,
    input  logic [NrPorts-1:0]                     req_we_i,
    output logic                                   mem_valid_o,
    input  logic                                   mem_ready_i,
    output logic [AddrWidth-1:0]                   mem_addr_o,
    output logic                                   mem_we_o,
    output logic [IdWidth-1:0]                     mem_id_o,
    input  logic                                   rsp_valid_i,
    input  logic [IdWidth-1:0]                     rsp_id_i,
    output logic [$clog2(MaxOutstanding+1)-1:0]    outstanding_o
);

    localparam int unsigned IdxWidth = (NrPorts > 1) ? $clog2(NrPorts) : 1;
    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
    localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);

    sched_state_e        state_q, state_d;
    logic [IdxWidth-1:0] ptr_q, ptr_next;
    logic [IdxWidth-1:0] drain_idx_q;
    logic                ni_q;
    logic [AddrWidth-1:0] mem_addr_q;
    logic                mem_we_q;
    logic [IdWidth-1:0]  mem_id_q;
    logic [CntWidth-1:0] cnt_q;

    logic [IdxWidth-1:0] winner, cap_idx;
    logic                any_valid, winner_ni;
    logic                capture, set_ni, clr_ni, latch_drain;
    logic                mem_hs, rsp_dec;
    ni_rule_tab_t        ni_base_tab, ni_len_tab;

    mem_sched_rr_pick #(
        .NrPorts  (NrPorts),
        .IdxWidth (IdxWidth)
    ) i_rr_pick (
        .valid     (req_valid_i),
        .ptr       (ptr_q),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // Widen the region rules into the package's fixed-size table.
    always_comb begin
        ni_base_tab = '0;
        ni_len_tab  = '0;
        for (int unsigned r = 0; r < NrNiRules; r++) begin
            ni_base_tab[r] = MaxAddrWidth'(NiAddrBase[r]);
            ni_len_tab[r]  = MaxAddrWidth'(NiLength[r]);
        end
    end

    assign winner_ni = is_non_idempotent(MaxAddrWidth'(req_addr_i[winner]), ni_base_tab, ni_len_tab, NrNiRules);

    // Next-state and capture decision; capture only ever happens from ARB or DRAIN.
    always_comb begin
        state_d     = state_q;
        capture     = 1'b0;
        cap_idx     = winner;
        set_ni      = 1'b0;
        clr_ni      = 1'b0;
        latch_drain = 1'b0;
        case (state_q)
            ARB: begin
                if (any_valid) begin
                    if (winner_ni) begin
                        if (cnt_q == '0) begin
                            capture = 1'b1;
                            set_ni  = 1'b1;
                            state_d = HOLD;
                        end else begin
                            latch_drain = 1'b1;
                            state_d     = DRAIN;
                        end
                    end else if (cnt_q < MaxCnt) begin
                        capture = 1'b1;
                        state_d = HOLD;
                    end
                end
            end
            DRAIN: begin
                cap_idx = drain_idx_q;
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    set_ni  = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (mem_ready_i) begin
                    state_d = ni_q ? SERIAL : ARB;
                end
            end
            SERIAL: begin
                if (rsp_valid_i && (rsp_id_i == mem_id_q)) begin
                    clr_ni  = 1'b1;
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    // One-hot ready strobe for the captured port and the rotated pointer.
    always_comb begin
        req_ready_o = '0;
        if (capture) begin
            req_ready_o[cap_idx] = 1'b1;
        end
        if (cap_idx == IdxWidth'(NrPorts - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = cap_idx + IdxWidth'(1);
        end
    end

    // State, pointer and captured request registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ARB;
            ptr_q       <= '0;
            drain_idx_q <= '0;
            ni_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_id_q    <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                ptr_q      <= ptr_next;
                mem_addr_q <= req_addr_i[cap_idx];
                mem_we_q   <= req_we_i[cap_idx];
                mem_id_q   <= IdWidth'(cap_idx);
            end
            if (latch_drain) begin
                drain_idx_q <= winner;
            end
            if (set_ni) begin
                ni_q <= 1'b1;
            end else if (clr_ni) begin
                ni_q <= 1'b0;
            end
        end
    end

    assign mem_hs  = (state_q == HOLD) && mem_ready_i;
    assign rsp_dec = rsp_valid_i && (cnt_q != '0);

    // In-flight counter; a response with nothing in flight is dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            case ({mem_hs, rsp_dec})
                2'b10:   cnt_q <= cnt_q + CntWidth'(1);
                2'b01:   cnt_q <= cnt_q - CntWidth'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign mem_valid_o   = (state_q == HOLD);
    assign mem_addr_o    = mem_addr_q;
    assign mem_we_o      = mem_we_q;
    assign mem_id_o      = mem_id_q;
    assign outstanding_o = cnt_q;

endmodule
